asteroid_scheduler: RTL and testbench
=====================================

# asteroid_scheduler

Spawns, tracks and retires up to NUM_SLOTS on-screen asteroids. Each slot drives one asteroid mover instance through its `asteroid_on` enable. The block owns game-run sequencing (idle, run, paused, over) and drives a common `mov_halt` to all movers. It uses an LFSR to choose spawn gaps and lanes, and sits between the game-control logic (start/pause/collision) and the per-asteroid movers.

## Interface
- NUM_SLOTS, 4: asteroid slots and movers served.
- TICK_DIV, 251250: clk cycles per movement tick; equals the movers' step period.
- MIN_GAP, 60: minimum ticks between spawns.
- GAP_MASK, 8'h3F: mask on the LFSR to form the random extra gap.
- X_LIMIT, 10'd640: mover x at or above this retires the slot.
- LFSR_SEED, 16'hACE1: nonzero LFSR reset value.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins or restarts a game.
- pause  in  1  one-cycle pulse; toggles RUN/PAUSED.
- hit  in  1  collision level from collision logic.
- xpos  in  10*NUM_SLOTS  flattened mover x positions; slot i is at [10i+9:10i].
- asteroid_on  out  NUM_SLOTS  per-slot mover enable.
- lane  out  2*NUM_SLOTS  per-slot lane index (0..3), valid while the slot is on.
- mov_halt  out  1  halt to all movers; high unless state is RUN.
- spawn  out  1  one-cycle pulse when a slot is activated.
- game_over  out  1  high in OVER.

## Operation
- States: IDLE, RUN, PAUSED, OVER. Reset state is IDLE.
- IDLE: on `start`, go to RUN, clear all slots, and load the gap counter with MIN_GAP.
- RUN: on `hit`, go to OVER (highest priority). Otherwise, on `pause`, go to PAUSED.
- PAUSED: on `pause`, go to RUN. On `start`, do a full restart as from IDLE. `hit` is ignored.
- OVER: on `start`, do a full restart. Slots and lanes stay frozen until then.
- Tick counter: counts 0..TICK_DIV-1 only in RUN and holds its value otherwise. `tick` is asserted in the cycle where the count equals TICK_DIV-1.
- Gap counter: decrements on each tick while nonzero.
- Spawn request:
  - A request is pending when the gap counter is 0.
  - The request is served when any slot is free: choose the lowest-index free slot, set its `asteroid_on`, set its `lane` to lfsr[1:0], and pulse `spawn`.
  - Then reload the gap counter with MIN_GAP + (lfsr[7:0] & GAP_MASK).
  - With no free slot, the request stays pending. No reload happens and nothing is dropped.
- Retire: in RUN, a slot with `asteroid_on` high and `xpos` >= X_LIMIT clears `asteroid_on`.
- LFSR: 16-bit Galois, taps 0xB400. Steps every clk in every state except IDLE. It advances once more on each spawn so the lane and gap bits differ.
- A slot that retires is not eligible for spawn in the same cycle. It is free from the next cycle, so the mover sees at least one cycle of `asteroid_on`=0 and clears its position.
- Full restart: all `asteroid_on`=0, tick counter 0, gap counter MIN_GAP. The LFSR is not reseeded.

## Timing
- Reset values: asteroid_on=0, lane=0, mov_halt=1, spawn=0, game_over=0, state IDLE, tick counter=0, gap counter=0, LFSR=LFSR_SEED.
- All outputs are registered.
- mov_halt and game_over follow the state register with zero extra latency.
- `start` in IDLE: state is RUN and mov_halt=0 on the next edge.
- First spawn occurs MIN_GAP ticks after start, i.e. MIN_GAP*TICK_DIV cycles, ±1 cycle.
- `spawn` and the `asteroid_on` rise land on the same edge.
- Retire: `asteroid_on` falls on the edge after `xpos` crosses X_LIMIT (1-cycle latency).
- `hit` and `pause` in the same cycle in RUN: go to OVER.
- `start` together with any other input: restart wins.
- Reset asserted mid-game: all outputs go to reset values immediately (asynchronous). Release is synchronous to clk.

## Structure
- Shared package `asteroid_pkg`: state enum (IDLE, RUN, PAUSED, OVER), X width constant (10), lane width (2), LFSR taps constant.
- One sub-module: `lfsr16` (clk, reset_n, en, seed param, q). Slot allocation is a priority encoder written inline.

## Test plan
- TICK_DIV=4, MIN_GAP=2, reset, then `start` -> mov_halt falls next edge; `spawn` occurs 8±1 cycles later on slot 0 with `asteroid_on`=4'b0001.
- Drive xpos[slot0]=640 while slot 0 is on -> asteroid_on[0]=0 one cycle later; the next spawn reuses slot 0 no earlier than the following cycle.
- Hold all xpos < 640 until 4 slots are full -> a pending spawn fires within 1 cycle after the first retire. No spawn occurs while full, and exactly one spawn occurs after the retire.
- `pause` pulse in RUN -> mov_halt=1, tick and gap counters frozen for 100 cycles; second `pause` -> spawn timing resumes from the frozen count.
- `hit` and `pause` in the same cycle -> OVER, game_over=1, asteroid_on frozen; then `start` -> all asteroid_on=0, RUN.
- Assert reset_n low mid-RUN between clock edges -> outputs reach reset values before the next edge. After release, the sequence from `start` repeats identically, since the LFSR is reseeded only by reset.

Source files
------------

// File: rtl/asteroid_pkg.sv
// asteroid_pkg: shared types and constants for the asteroid scheduler.
//   state_e     game-run state (idle, run, paused, over)
//   XWidth      mover x-position width
//   LaneWidth   lane index width
//   LfsrTaps    Galois feedback taps for the 16-bit LFSR
//   lfsr_step   one right-shift Galois step
package asteroid_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StOver} state_e;

  localparam int unsigned XWidth    = 10;
  localparam int unsigned LaneWidth = 2;
  localparam logic [15:0] LfsrTaps  = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {1'b0, q[15:1]} ^ (q[0] ? LfsrTaps : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR with a single- or double-step advance.
//   i_clk      system clock, rising edge
//   i_reset_n  asynchronous active-low reset, loads SEED
//   i_en       advance one step this cycle
//   i_extra    with i_en, advance a second step in the same cycle
//   o_q        current register value
module lfsr16
  import asteroid_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en,
  input  logic        i_extra,
  output logic [15:0] o_q
);

  logic [15:0] r_q;
  logic [15:0] w_one;
  logic [15:0] w_next;

  always_comb begin
    w_one  = lfsr_step(r_q);
    w_next = i_extra ? lfsr_step(w_one) : w_one;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_q <= SEED;
    end else if (i_en) begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/asteroid_scheduler.sv
// asteroid_scheduler: spawns, tracks and retires on-screen asteroids and sequences the game.
//   i_clk          system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_start        pulse: begin or restart a game (wins over every other input)
//   i_pause        pulse: toggle run/paused
//   i_hit          collision level; ends the game while running
//   i_xpos         flattened mover x positions, slot i at [10i+9:10i]
//   o_asteroid_on  per-slot mover enable
//   o_lane         per-slot lane index, slot i at [2i+1:2i]
//   o_mov_halt     halt to all movers, high unless running
//   o_spawn        one-cycle pulse when a slot is activated
//   o_game_over    high while the game is over
module asteroid_scheduler
  import asteroid_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned TICK_DIV  = 251250,
  parameter int unsigned MIN_GAP   = 60,
  parameter logic [7:0]  GAP_MASK  = 8'h3F,
  parameter logic [9:0]  X_LIMIT   = 10'd640,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_start,
  input  logic                           i_pause,
  input  logic                           i_hit,
  input  logic [XWidth*NUM_SLOTS-1:0]    i_xpos,
  output logic [NUM_SLOTS-1:0]           o_asteroid_on,
  output logic [LaneWidth*NUM_SLOTS-1:0] o_lane,
  output logic                           o_mov_halt,
  output logic                           o_spawn,
  output logic                           o_game_over
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GapW  = $clog2(MIN_GAP + 256);
  localparam int unsigned SlotW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  state_e                         r_state, w_state_d;
  logic [TickW-1:0]               r_tick_cnt, w_tick_cnt_d;
  logic [GapW-1:0]                r_gap, w_gap_d;
  logic [NUM_SLOTS-1:0]           r_on, w_on_d;
  logic [LaneWidth*NUM_SLOTS-1:0] r_lane, w_lane_d;
  logic                           r_spawn, w_spawn_d;
  logic                           r_halt, r_over;
  logic                           w_restart, w_run, w_tick, w_any_free;
  logic [SlotW-1:0]               w_free_idx;
  logic [15:0]                    w_lfsr;
  logic                           w_unused_lfsr;

  assign w_run         = (r_state == StRun);
  assign w_tick        = w_run && (r_tick_cnt == TickW'(TICK_DIV - 1));
  assign w_unused_lfsr = ^w_lfsr[15:8];

  // Steps every cycle outside idle; a spawn adds a second step so lane and gap bits decorrelate.
  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_en     (r_state != StIdle),
    .i_extra  (w_spawn_d),
    .o_q      (w_lfsr)
  );

  always_comb begin
    w_state_d = r_state;
    w_restart = 1'b0;
    if (i_start) begin
      w_state_d = StRun;
      w_restart = 1'b1;
    end else begin
      unique case (r_state)
        StRun: begin
          if (i_hit) begin
            w_state_d = StOver;
          end else if (i_pause) begin
            w_state_d = StPaused;
          end
        end
        StPaused: begin
          if (i_pause) begin
            w_state_d = StRun;
          end
        end
        default: w_state_d = r_state;
      endcase
    end
  end

  always_comb begin
    w_tick_cnt_d = r_tick_cnt;
    w_gap_d      = r_gap;
    w_on_d       = r_on;
    w_lane_d     = r_lane;
    w_spawn_d    = 1'b0;
    w_any_free   = 1'b0;
    w_free_idx   = '0;
    // Descending scan so the lowest free index is the one left standing.
    // Free is judged on the registered enables, so a slot retiring this cycle is not eligible.
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!r_on[i]) begin
        w_any_free = 1'b1;
        w_free_idx = SlotW'(i);
      end
    end
    if (w_restart) begin
      w_tick_cnt_d = '0;
      w_gap_d      = GapW'(MIN_GAP);
      w_on_d       = '0;
    end else if (w_run) begin
      w_tick_cnt_d = w_tick ? '0 : r_tick_cnt + 1'b1;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        if (r_on[i] && (i_xpos[XWidth*i +: XWidth] >= X_LIMIT)) begin
          w_on_d[i] = 1'b0;
        end
      end
      // A zero gap is a pending request; it waits here until a slot frees up.
      if (r_gap == '0) begin
        if (w_any_free) begin
          w_on_d[w_free_idx]                           = 1'b1;
          w_lane_d[LaneWidth*w_free_idx +: LaneWidth]  = w_lfsr[1:0];
          w_spawn_d                                    = 1'b1;
          w_gap_d = GapW'(MIN_GAP) + GapW'(w_lfsr[7:0] & GAP_MASK);
        end
      end else if (w_tick) begin
        w_gap_d = r_gap - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= StIdle;
      r_tick_cnt <= '0;
      r_gap      <= '0;
      r_on       <= '0;
      r_lane     <= '0;
      r_spawn    <= 1'b0;
      r_halt     <= 1'b1;
      r_over     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_tick_cnt <= w_tick_cnt_d;
      r_gap      <= w_gap_d;
      r_on       <= w_on_d;
      r_lane     <= w_lane_d;
      r_spawn    <= w_spawn_d;
      // Decoded from the next state so these flops track the state register exactly.
      r_halt     <= (w_state_d != StRun);
      r_over     <= (w_state_d == StOver);
    end
  end

  assign o_asteroid_on = r_on;
  assign o_lane        = r_lane;
  assign o_mov_halt    = r_halt;
  assign o_spawn       = r_spawn;
  assign o_game_over   = r_over;

endmodule

// File: tb/tb_asteroid_scheduler.sv
// Scoreboard bench: stimulus pushes expected spawns, a negedge monitor pops and checks them.
module tb_asteroid_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        hit = 1'b0;
  logic [39:0] xpos = '0;
  logic [3:0]  on;
  logic [7:0]  lane;
  logic        halt, spawn, over;

  asteroid_scheduler #(
    .NUM_SLOTS(4),
    .TICK_DIV (4),
    .MIN_GAP  (2),
    .GAP_MASK (8'h3F),
    .X_LIMIT  (10'd640),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_start      (start),
    .i_pause      (pause),
    .i_hit        (hit),
    .i_xpos       (xpos),
    .o_asteroid_on(on),
    .o_lane       (lane),
    .o_mov_halt   (halt),
    .o_spawn      (spawn),
    .o_game_over  (over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0] on;
    logic       chk_lane;
    logic [1:0] slot;
    logic [1:0] lane;
    int         min_cyc;
    int         max_cyc;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass = 0;
  int   n_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_win(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: at cycle %0d, expected cycle %0d..%0d", name, act, lo, hi);
  endtask

  task automatic push(input logic [3:0] e_on, input logic chk, input logic [1:0] slot,
                      input logic [1:0] e_lane, input int lo, input int hi, input int id);
    exp_t e;
    e.on = e_on; e.chk_lane = chk; e.slot = slot; e.lane = e_lane;
    e.min_cyc = lo; e.max_cyc = hi; e.id = id;
    exp_q.push_back(e);
  endtask

  // Monitor: every spawn pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && spawn) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_spawn: spawn at cycle %0d with asteroid_on=%b, none expected",
                 cyc, on);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("spawn%0d_on", mon_e.id), {28'd0, on}, {28'd0, mon_e.on});
        if (mon_e.chk_lane)
          check($sformatf("spawn%0d_lane", mon_e.id), {30'd0, lane[2*mon_e.slot +: 2]},
                {30'd0, mon_e.lane});
        check_win($sformatf("spawn%0d_time", mon_e.id), cyc, mon_e.min_cyc, mon_e.max_cyc);
        n_seen++;
      end
    end
  end

  task automatic wait_seen(input int target, input int budget, input string name);
    int k = 0;
    while (n_seen < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, n_seen >= target}, 32'd1);
  endtask

  // Called at a negedge; returns at the negedge right after the sampling edge.
  task automatic pulse_start(output int t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = cyc;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_on"}, {28'd0, on}, 32'd0);
    check({tag, "_lane"}, {24'd0, lane}, 32'd0);
    check({tag, "_halt"}, {31'd0, halt}, 32'd1);
    check({tag, "_spawn"}, {31'd0, spawn}, 32'd0);
    check({tag, "_over"}, {31'd0, over}, 32'd0);
  endtask

  initial begin
    int t, c, q;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_halt", {31'd0, halt}, 32'd1);

    // First game: seed 0xACE1 stepped 8 times gives 0xC2C4 -> lane 0, next gap 2+4=6 ticks.
    pulse_start(t);
    check("start_halt", {31'd0, halt}, 32'd0);
    check("start_over", {31'd0, over}, 32'd0);
    push(4'b0001, 1'b1, 2'd0, 2'd0, t + 7, t + 9, 0);
    push(4'b0011, 1'b0, 2'd0, 2'd0, t + 33, t + 33, 1);
    wait_seen(2, 60, "first_spawns_seen");

    // Retire slot 0, then it must be reused.
    xpos[9:0] = 10'd640;
    @(negedge clk);
    check("retire_slot0", {28'd0, on}, 32'h2);
    xpos[9:0] = 10'd0;
    push(4'b0011, 1'b0, 2'd0, 2'd0, cyc + 1, cyc + 300, 2);
    wait_seen(3, 310, "reuse_slot0_seen");
    push(4'b0111, 1'b0, 2'd0, 2'd0, cyc + 1, cyc + 300, 3);
    wait_seen(4, 310, "fill_slot2_seen");
    push(4'b1111, 1'b0, 2'd0, 2'd0, cyc + 1, cyc + 300, 4);
    wait_seen(5, 310, "fill_slot3_seen");

    // Full: the request stays pending, then fires on the cycle after a retire.
    repeat (300) @(negedge clk);
    check("full_hold", {28'd0, on}, 32'hF);
    xpos[29:20] = 10'd640;
    c = cyc;
    @(negedge clk);
    check("retire_slot2", {28'd0, on}, 32'hB);
    xpos[29:20] = 10'd0;
    push(4'b1111, 1'b0, 2'd0, 2'd0, c + 2, c + 2, 5);
    wait_seen(6, 10, "pending_spawn_seen");
    repeat (20) @(negedge clk);
    check("single_refill", {28'd0, on}, 32'hF);

    // Restart from RUN, pause with tick count at 3 and gap 2; resume needs 6 more cycles.
    pulse_start(t);
    check("restart_clears", {28'd0, on}, 32'd0);
    check("restart_halt", {31'd0, halt}, 32'd0);
    repeat (2) @(negedge clk);
    pulse_pause();
    check("paused_halt", {31'd0, halt}, 32'd1);
    repeat (100) @(negedge clk);
    check("paused_halt_hold", {31'd0, halt}, 32'd1);
    check("paused_no_spawn", {28'd0, on}, 32'd0);
    pulse_pause();
    q = cyc;
    check("resume_halt", {31'd0, halt}, 32'd0);
    push(4'b0001, 1'b0, 2'd0, 2'd0, q + 6, q + 6, 6);
    wait_seen(7, 20, "resume_spawn_seen");

    // Hit and pause together go to over; slots freeze, no retire.
    hit = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    pause = 1'b0;
    check("over_flag", {31'd0, over}, 32'd1);
    check("over_halt", {31'd0, halt}, 32'd1);
    xpos[9:0] = 10'd640;
    repeat (20) @(negedge clk);
    check("over_frozen", {28'd0, on}, 32'h1);
    pulse_start(t);
    xpos[9:0] = 10'd0;
    check("over_restart_on", {28'd0, on}, 32'd0);
    check("over_restart_over", {31'd0, over}, 32'd0);
    check("over_restart_halt", {31'd0, halt}, 32'd0);
    push(4'b0001, 1'b0, 2'd0, 2'd0, t + 7, t + 9, 7);
    wait_seen(8, 20, "over_restart_spawn_seen");

    // Start with hit in RUN: restart wins.
    start = 1'b1;
    hit = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    t = cyc;
    check("start_hit_over", {31'd0, over}, 32'd0);
    check("start_hit_halt", {31'd0, halt}, 32'd0);
    check("start_hit_on", {28'd0, on}, 32'd0);
    push(4'b0001, 1'b0, 2'd0, 2'd0, t + 7, t + 9, 8);
    wait_seen(9, 20, "start_hit_spawn_seen");

    // Asynchronous reset between edges, then the seeded sequence repeats.
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(t);
    push(4'b0001, 1'b1, 2'd0, 2'd0, t + 7, t + 9, 9);
    push(4'b0011, 1'b0, 2'd0, 2'd0, t + 33, t + 33, 10);
    wait_seen(11, 60, "post_reset_spawns_seen");

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
